pipe_skid_reg: RTL

Parametrised elastic pipeline register with a two-entry skid buffer, valid/ready handshake, synchronous flush and bubble injection. It replaces the fixed-field, stall/flush-only stage registers between CPU pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB). Each instance carries one packed payload bundle. Back-pressure is absorbed without a combinational ready path from output to input.

---
 rtl/pipe_pkg.sv | 65 ++++++
 rtl/pipe_skid_reg.sv | 85 ++++++++
 2 files changed

// File: rtl/pipe_pkg.sv
// Shared types for the elastic pipeline stage registers: occupancy state,
// per-boundary payload bundles and their bubble (NOP) values.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } pipe_state_e;

  localparam logic [6:0] OP_I_IMM = 7'b0010011;
  localparam logic [2:0] F3_ADD   = 3'b000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [6:0]  opcode;
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    logic [31:0] imm;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        rd_we;
    logic [4:0]  rd_addr;
  } id_ex_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] alu_result;
    logic [31:0] rs2_data;
    logic [2:0]  funct3;
    logic        mem_re;
    logic        mem_we;
    logic        rd_we;
    logic [4:0]  rd_addr;
  } ex_mem_t;

  typedef struct packed {
    logic [31:0] wb_data;
    logic        rd_we;
    logic [4:0]  rd_addr;
  } mem_wb_t;

  // addi x0, x0, 0 with no register write-back
  localparam id_ex_t ID_EX_NOP = '{
    pc: '0, opcode: OP_I_IMM, funct7: '0, funct3: F3_ADD, imm: '0,
    rs1_data: '0, rs2_data: '0, rd_we: 1'b0, rd_addr: '0
  };
  localparam if_id_t  IF_ID_NOP  = '0;
  localparam ex_mem_t EX_MEM_NOP = '0;
  localparam mem_wb_t MEM_WB_NOP = '0;

  function automatic logic [1:0] occ_of(input pipe_state_e s);
    case (s)
      ONE:     occ_of = 2'd1;
      FULL:    occ_of = 2'd2;
      default: occ_of = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_skid_reg.sv
// Elastic pipeline register: main (head) register plus one skid entry so that
// in_ready is a function of registered state only.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int unsigned       DATA_W = 128,
  parameter logic [DATA_W-1:0] BUBBLE = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  pipe_state_e       state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              in_fire, out_fire;

  assign in_ready  = (state_q != FULL) & ~rst;
  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;
  assign occupancy = occ_of(state_q);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (rst || flush) begin
      // a concurrent out_fire was already consumed downstream; nothing to do
      state_d = EMPTY;
      main_d  = BUBBLE;
      skid_d  = BUBBLE;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            main_d  = in_data;
            state_d = ONE;
          end
        end
        ONE: begin
          case ({in_fire, out_fire})
            2'b10: begin
              skid_d  = in_data;
              state_d = FULL;
            end
            2'b01: begin
              main_d  = BUBBLE;
              state_d = EMPTY;
            end
            2'b11: main_d = in_data;
            default: ;
          endcase
        end
        FULL: begin
          if (out_fire) begin
            main_d  = skid_q;
            state_d = ONE;
          end
        end
        default: begin
          state_d = EMPTY;
          main_d  = BUBBLE;
          skid_d  = BUBBLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    state_q <= state_d;
    main_q  <= main_d;
    skid_q  <= skid_d;
  end

endmodule
